// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard scoreboard.
package hazard_pkg;
    localparam int SB_ADDR_W = 4;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic [SB_ADDR_W-1:0] dest;
        logic                 mem_read;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and stall/forwarding response bundle.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] src_1;
    logic [REG_ADDR_W-1:0] src_2;
    logic                  two_src;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_mem_read;
    logic                  freeze;
    logic                  flush;
    logic                  hazard_detected;
    logic [SEL_W-1:0]      fwd_sel_1;
    logic [SEL_W-1:0]      fwd_sel_2;
    logic [CNT_W-1:0]      stall_count;
    modport master (
        output id_valid, src_1, src_2, two_src, id_wb_en, id_dest, id_mem_read, freeze, flush,
        input  hazard_detected, fwd_sel_1, fwd_sel_2, stall_count
    );
    modport slave (
        input  id_valid, src_1, src_2, two_src, id_wb_en, id_dest, id_mem_read, freeze, flush,
        output hazard_detected, fwd_sel_1, fwd_sel_2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// sb_match: finds the youngest in-flight entry writing a given source register.
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int KW    = 1
) (
    input  logic [SB_ADDR_W-1:0] src_i,
    input  logic                 en_i,
    input  sb_entry_t            ent_i [DEPTH],
    output logic                 any_o,
    output logic [KW-1:0]        k_o,
    output logic                 load_o
);
    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        any_o  = 1'b0;
        k_o    = '0;
        load_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (en_i && ent_i[k].valid && ent_i[k].wb_en && ent_i[k].dest == src_i) begin
                any_o  = 1'b1;
                k_o    = KW'(k);
                load_o = ent_i[k].mem_read;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writeback tracker raising ID stalls and counting them.
// Define FORWARDING_EN to stall only on load-use and drive EXE forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = SB_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int KW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int SEL_W = $clog2(DEPTH + 1);
    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_1, any_2, ld_1, ld_2, hz;
    logic [KW-1:0]    k_1, k_2;
    sb_match #(.DEPTH(DEPTH), .KW(KW)) u_match_1 (
        .src_i(sb.src_1), .en_i(1'b1), .ent_i(ent_q),
        .any_o(any_1), .k_o(k_1), .load_o(ld_1)
    );
    sb_match #(.DEPTH(DEPTH), .KW(KW)) u_match_2 (
        .src_i(sb.src_2), .en_i(sb.two_src), .ent_i(ent_q),
        .any_o(any_2), .k_o(k_2), .load_o(ld_2)
    );
`ifdef FORWARDING_EN
    assign hz = sb.id_valid & ((any_1 & (k_1 == '0) & ld_1) | (any_2 & (k_2 == '0) & ld_2));
    assign sb.fwd_sel_1 = any_1 ? SEL_W'(k_1) + SEL_W'(1) : SEL_W'(FWD_RF);
    assign sb.fwd_sel_2 = any_2 ? SEL_W'(k_2) + SEL_W'(1) : SEL_W'(FWD_RF);
`else
    logic unused_fwd;
    assign unused_fwd = ^{k_1, k_2, ld_1, ld_2};
    assign hz = sb.id_valid & (any_1 | any_2);
    assign sb.fwd_sel_1 = SEL_W'(FWD_RF);
    assign sb.fwd_sel_2 = SEL_W'(FWD_RF);
`endif
    assign sb.hazard_detected = hz;
    assign sb.stall_count     = cnt_q;
    // A stalled ID instruction becomes a bubble; flush then wins over freeze.
    always_comb begin
        ent_d[0] = sb.freeze ? ent_q[0] :
                   sb_entry_t'{valid: sb.id_valid & ~hz, wb_en: sb.id_wb_en,
                               dest: sb.id_dest, mem_read: sb.id_mem_read};
        for (int k = 1; k < DEPTH; k++)
            ent_d[k] = sb.freeze ? ent_q[k] : ent_q[k-1];
        for (int k = 0; k < DEPTH; k++)
            if (sb.flush) ent_d[k].valid = 1'b0;
        cnt_d = (hz & ~sb.freeze & ~sb.flush & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: queue-based checker for stall, forwarding and counter behaviour.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string       tag;
        logic        hz;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    hazard_scoreboard_if #(.REG_ADDR_W(4), .DEPTH(2), .CNT_W(16)) sbi ();
    hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sb(sbi)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic two, input logic wb, input logic [3:0] d, input logic mr,
                        input logic frz, input logic fl, input logic ehz, input logic [1:0] e1,
                        input logic [1:0] e2, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        sbi.id_valid = v; sbi.src_1 = a; sbi.src_2 = b; sbi.two_src = two;
        sbi.id_wb_en = wb; sbi.id_dest = d; sbi.id_mem_read = mr;
        sbi.freeze = frz; sbi.flush = fl;
        e.tag = tag; e.hz = ehz; e.s1 = e1; e.s2 = e2; e.cnt = ec;
        exp_q.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_hz"}, 32'(sbi.hazard_detected), 32'(e.hz));
                chk({e.tag, "_sel1"}, 32'(sbi.fwd_sel_1), 32'(e.s1));
                chk({e.tag, "_sel2"}, 32'(sbi.fwd_sel_2), 32'(e.s2));
                chk({e.tag, "_cnt"}, 32'(sbi.stall_count), 32'(e.cnt));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    task automatic preset_cnt();
        #3 force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
    endtask
    initial begin
        sbi.id_valid = 0; sbi.src_1 = 0; sbi.src_2 = 0; sbi.two_src = 0;
        sbi.id_wb_en = 0; sbi.id_dest = 0; sbi.id_mem_read = 0;
        sbi.freeze = 0; sbi.flush = 0;
        step("rst", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
        #4 rst = 1'b0;
`ifdef FORWARDING_EN
        step("alu",   1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0, 16'd0);
        step("fwd1",  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'd0);
        step("fwd2",  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 16'd0);
        step("ldr5",  1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 16'd0);
        step("lu",    1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 16'd0);
        step("lu_go", 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2, 16'd1);
        step("ldr5b", 1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 16'd1);
        step("two0",  1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);
        step("ldr6",  1, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 16'd1);
        step("frz1",  1, 6, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 16'd1);
        step("frz2",  1, 6, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 16'd1);
        step("unfrz", 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'd1);
        step("frzgo", 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 16'd2);
        step("ldr7",  1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 16'd2);
        step("flfz",  1, 7, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 16'd2);
        step("postfl",1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        preset_cnt();
        step("ldr9",  1, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 16'hFFFE);
        step("sat1",  1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFE);
        step("ldr10", 1, 9, 0, 0, 1, 10, 1, 0, 0, 0, 2, 0, 16'hFFFF);
        step("sat2",  1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFF);
        step("ldr11", 1, 10, 0, 0, 1, 11, 1, 0, 0, 0, 2, 0, 16'hFFFF);
        step("sat3",  1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFF);
        step("ldr12", 1, 11, 0, 0, 1, 12, 1, 0, 0, 0, 2, 0, 16'hFFFF);
        step("sat4",  1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFF);
`else
        step("add3",  1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0, 16'd0);
        step("sub_a", 1, 3, 1, 1, 1, 4, 0, 0, 0, 1, 0, 0, 16'd0);
        step("sub_b", 1, 3, 1, 1, 1, 4, 0, 0, 0, 1, 0, 0, 16'd1);
        step("sub_go",1, 3, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 16'd2);
        step("two0",  1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        step("two1",  1, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'd2);
        step("two1go",1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'd3);
        step("w15",   1, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 16'd3);
        step("r15",   1, 15, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'd3);
        step("frz1",  1, 15, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd4);
        step("frz2",  1, 15, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd4);
        step("frz3",  1, 15, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd4);
        step("unfrz", 1, 15, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'd4);
        step("w7",    1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 16'd5);
        step("flfz",  1, 7, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd5);
        step("postfl",1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd5);
        preset_cnt();
        step("w9",    1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 16'hFFFE);
        step("sat1",  1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFE);
        step("sat2",  1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF);
        step("w10",   1, 9, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        step("sat3",  1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF);
        step("sat4",  1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF);
`endif
        #3 rst = 1'b1;
        #1;
        chk("arst_hz", 32'(sbi.hazard_detected), 32'd0);
        chk("arst_sel1", 32'(sbi.fwd_sel_1), 32'd0);
        chk("arst_sel2", 32'(sbi.fwd_sel_2), 32'd0);
        chk("arst_cnt", 32'(sbi.stall_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
